// File: rtl/cam_capture.sv
`default_nettype none
// ============================================================================
// Module   : cam_capture
// Brief    : Oversampled OV7670-style byte stream to RGB444 frame-buffer writes.
//            Define CAM_CAPTURE_TESTPAT_EN to replace pixel data with colour bars.
// Revision : 1.0 - initial release
// ============================================================================
module cam_capture #(
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240,
  parameter int ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              enable,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [11:0]       pix_data,
  output logic              pix_we,
  output logic              frame_done,
  output logic [7:0]        frame_count,
  output logic              line_err,
  output logic              overflow
);

  localparam int unsigned             C_PIX_TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int                      C_COL_W     = $clog2(H_ACTIVE + 1);
  localparam logic [C_COL_W-1:0]      C_COL_LAST  = H_ACTIVE[C_COL_W-1:0];
  localparam logic [C_COL_W-1:0]      C_COL_MAX   = '1;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_CAPTURE    = 2'd2
  } state_t;

  // Two-flop synchronizers plus one delay stage for edge detection
  logic [1:0] pclk_sync_q, vsync_sync_q, href_sync_q;
  logic [7:0] data_meta_q, data_sync_q;
  logic       pclk_dly_q, vsync_dly_q, href_dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pclk_sync_q  <= 2'b00;
      vsync_sync_q <= 2'b00;
      href_sync_q  <= 2'b00;
      data_meta_q  <= 8'h00;
      data_sync_q  <= 8'h00;
      pclk_dly_q   <= 1'b0;
      vsync_dly_q  <= 1'b0;
      href_dly_q   <= 1'b0;
    end else begin
      pclk_sync_q  <= {pclk_sync_q[0], cam_pclk};
      vsync_sync_q <= {vsync_sync_q[0], cam_vsync};
      href_sync_q  <= {href_sync_q[0], cam_href};
      data_meta_q  <= cam_data;
      data_sync_q  <= data_meta_q;
      pclk_dly_q   <= pclk_sync_q[1];
      vsync_dly_q  <= vsync_sync_q[1];
      href_dly_q   <= href_sync_q[1];
    end
  end

  // Registered stream events; the FSM acts on these one cycle later
  logic       byte_ev_d, byte_ev_q;
  logic [7:0] byte_d, byte_q;
  logic       href_fall_d, href_fall_q;
  logic       vsync_rise_d, vsync_rise_q;
  logic       vsync_fall_d, vsync_fall_q;

  always_comb begin
    byte_ev_d    = pclk_sync_q[1] & ~pclk_dly_q & href_sync_q[1];
    byte_d       = data_sync_q;
    href_fall_d  = ~href_sync_q[1] & href_dly_q;
    vsync_rise_d = vsync_sync_q[1] & ~vsync_dly_q;
    vsync_fall_d = ~vsync_sync_q[1] & vsync_dly_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_ev_q    <= 1'b0;
      byte_q       <= 8'h00;
      href_fall_q  <= 1'b0;
      vsync_rise_q <= 1'b0;
      vsync_fall_q <= 1'b0;
    end else begin
      byte_ev_q    <= byte_ev_d;
      byte_q       <= byte_d;
      href_fall_q  <= href_fall_d;
      vsync_rise_q <= vsync_rise_d;
      vsync_fall_q <= vsync_fall_d;
    end
  end

  state_t              state_d, state_q;
  logic                phase_d, phase_q;
  logic [6:0]          hi_d, hi_q;
  logic [C_COL_W-1:0]  col_d, col_q;
  logic [ADDR_W-1:0]   pix_addr_d, pix_addr_q;
  logic [11:0]         pix_data_d, pix_data_q;
  logic                pix_we_d, pix_we_q;
  logic                frame_done_d, frame_done_q;
  logic [7:0]          frame_count_d, frame_count_q;
  logic                line_err_d, line_err_q;
  logic                overflow_d, overflow_q;
  logic [11:0]         w_pix_rgb;

`ifdef CAM_CAPTURE_TESTPAT_EN
  localparam logic [C_COL_W+2:0] C_BAR_DIV = H_ACTIVE[C_COL_W+2:0];

  logic [C_COL_W+2:0] w_bar_quot;
  logic               w_unused_cam;

  assign w_bar_quot   = {col_q, 3'b000} / C_BAR_DIV;
  assign w_pix_rgb    = {{4{w_bar_quot[2]}}, {4{w_bar_quot[1]}}, {4{w_bar_quot[0]}}};
  assign w_unused_cam = ^{hi_q, w_bar_quot[C_COL_W+2:3]};
`else
  // hi_q keeps {R[4:1], G[5:3]}; 5/6/5 is truncated to 4/4/4
  assign w_pix_rgb = {hi_q[6:3], hi_q[2:0], byte_q[7], byte_q[4:1]};
`endif

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    hi_d          = hi_q;
    col_d         = col_q;
    pix_addr_d    = pix_addr_q;
    pix_data_d    = pix_data_q;
    pix_we_d      = 1'b0;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    line_err_d    = line_err_q;
    overflow_d    = overflow_q;

    if (pix_we_q) begin
      pix_addr_d = pix_addr_q + ADDR_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_WAIT_FRAME;
        end
      end

      ST_WAIT_FRAME: begin
        if (vsync_fall_q) begin
          state_d    = ST_CAPTURE;
          pix_addr_d = '0;
          phase_d    = 1'b0;
          col_d      = '0;
          line_err_d = 1'b0;
          overflow_d = 1'b0;
        end
      end

      ST_CAPTURE: begin
        // A byte landing on the frame-end cycle is dropped so frame_done never meets pix_we
        if (byte_ev_q && !vsync_rise_q) begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            hi_d = {byte_q[7:4], byte_q[2:0]};
          end else begin
            if (col_q != C_COL_MAX) begin
              col_d = col_q + C_COL_W'(1);
            end
            if (32'(pix_addr_q) >= C_PIX_TOTAL) begin
              overflow_d = 1'b1;
            end else begin
              pix_we_d   = 1'b1;
              pix_data_d = w_pix_rgb;
            end
          end
        end

        if (href_fall_q) begin
          if (phase_q || (col_q != C_COL_LAST)) begin
            line_err_d = 1'b1;
          end
          phase_d = 1'b0;
          col_d   = '0;
        end

        if (vsync_rise_q) begin
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 8'd1;
          state_d       = enable ? ST_WAIT_FRAME : ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      phase_q       <= 1'b0;
      hi_q          <= 7'h00;
      col_q         <= '0;
      pix_addr_q    <= '0;
      pix_data_q    <= 12'h000;
      pix_we_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= 8'h00;
      line_err_q    <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      hi_q          <= hi_d;
      col_q         <= col_d;
      pix_addr_q    <= pix_addr_d;
      pix_data_q    <= pix_data_d;
      pix_we_q      <= pix_we_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      line_err_q    <= line_err_d;
      overflow_q    <= overflow_d;
    end
  end

  assign pix_addr    = pix_addr_q;
  assign pix_data    = pix_data_q;
  assign pix_we      = pix_we_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign line_err    = line_err_q;
  assign overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_cam_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_capture
// Brief    : Directed self-checking bench for cam_capture on a reduced 8x3 frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cam_capture;

  localparam int H     = 8;
  localparam int V     = 3;
  localparam int AW    = 5;
  localparam int TOTAL = H * V;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          cam_pclk  = 1'b0;
  logic          cam_vsync = 1'b0;
  logic          cam_href  = 1'b0;
  logic [7:0]    cam_data  = 8'h00;
  logic          enable    = 1'b0;
  logic [AW-1:0] pix_addr;
  logic [11:0]   pix_data;
  logic          pix_we;
  logic          frame_done;
  logic [7:0]    frame_count;
  logic          line_err;
  logic          overflow;

  int n_vec     = 0;
  int n_bad     = 0;
  int fd_cnt    = 0;
  int clash_cnt = 0;
  int fd0;

  logic [AW-1:0] wr_addr_q[$];
  logic [11:0]   wr_data_q[$];

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [11:0] exp;
  } vec_t;
  vec_t vecs[H];

  always #5 clk = ~clk;

  cam_capture #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .ADDR_W   (AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cam_pclk    (cam_pclk),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_data    (cam_data),
    .enable      (enable),
    .pix_addr    (pix_addr),
    .pix_data    (pix_data),
    .pix_we      (pix_we),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .line_err    (line_err),
    .overflow    (overflow)
  );

  always @(negedge clk) begin
    if (pix_we) begin
      wr_addr_q.push_back(pix_addr);
      wr_data_q.push_back(pix_data);
    end
    if (frame_done) fd_cnt++;
    if (pix_we && frame_done) clash_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); cam_data = b;
    @(negedge clk); cam_pclk = 1'b1;
    @(negedge clk);
    @(negedge clk); cam_pclk = 1'b0;
  endtask

  task automatic send_pixel(input logic [7:0] hi, input logic [7:0] lo);
    send_byte(hi);
    send_byte(lo);
  endtask

  task automatic send_line(input int npix, input logic [7:0] hi, input logic [7:0] lo,
                           input bit extra);
    @(negedge clk); cam_href = 1'b1;
    for (int i = 0; i < npix; i++) send_pixel(hi, lo);
    if (extra) send_byte(hi);
    @(negedge clk); cam_href = 1'b0;
    tick(5);
  endtask

  task automatic frame_start;
    @(negedge clk); cam_vsync = 1'b1;
    tick(4);
    cam_vsync = 1'b0;
    tick(6);
  endtask

  task automatic frame_end;
    @(negedge clk); cam_vsync = 1'b1;
    tick(8);
  endtask

  task automatic clear_log;
    wr_addr_q.delete();
    wr_data_q.delete();
    fd0 = fd_cnt;
  endtask

  initial begin
    // RGB565 byte pairs and their truncated RGB444 result
    vecs[0] = '{8'hF8, 8'h1F, 12'hF0F};
    vecs[1] = '{8'h07, 8'hE0, 12'h0F0};
    vecs[2] = '{8'h00, 8'h1F, 12'h00F};
    vecs[3] = '{8'h00, 8'h61, 12'h000};
    vecs[4] = '{8'hFF, 8'hFF, 12'hFFF};
    vecs[5] = '{8'hA5, 8'h3C, 12'hAAE};
    vecs[6] = '{8'h5A, 8'hC3, 12'h551};
    vecs[7] = '{8'h08, 8'h80, 12'h010};

    tick(3);
    check("rst_addr",   32'(pix_addr),    32'd0);
    check("rst_data",   32'(pix_data),    32'd0);
    check("rst_we",     32'(pix_we),      32'd0);
    check("rst_fd",     32'(frame_done),  32'd0);
    check("rst_fcount", 32'(frame_count), 32'd0);
    check("rst_lerr",   32'(line_err),    32'd0);
    check("rst_ovf",    32'(overflow),    32'd0);
    @(negedge clk); rst_n = 1'b1; enable = 1'b1;
    tick(2);

    // Full frame of one colour
    clear_log();
    frame_start();
    for (int l = 0; l < V; l++) send_line(H, 8'hF8, 8'h1F, 1'b0);
    frame_end();
    check("f1_writes", 32'(wr_addr_q.size()), 32'(TOTAL));
    foreach (wr_addr_q[i]) begin
      check("f1_addr", 32'(wr_addr_q[i]), 32'(i));
      check("f1_data", 32'(wr_data_q[i]), 32'h0F0F);
    end
    check("f1_last_addr",
          (wr_addr_q.size() > 0) ? 32'(wr_addr_q[wr_addr_q.size()-1]) : 32'hFFFF_FFFF,
          32'(TOTAL - 1));
    check("f1_fd",     32'(fd_cnt - fd0),  32'd1);
    check("f1_fcount", 32'(frame_count),   32'd1);
    check("f1_lerr",   32'(line_err),      32'd0);
    check("f1_ovf",    32'(overflow),      32'd0);

    // Table-driven conversion vectors on line 0
    clear_log();
    frame_start();
    @(negedge clk); cam_href = 1'b1;
    for (int i = 0; i < H; i++) send_pixel(vecs[i].hi, vecs[i].lo);
    @(negedge clk); cam_href = 1'b0;
    tick(5);
    for (int l = 1; l < V; l++) send_line(H, 8'h00, 8'h1F, 1'b0);
    frame_end();
    check("f2_writes", 32'(wr_addr_q.size()), 32'(TOTAL));
    for (int i = 0; i < H; i++) begin
      if (i < wr_addr_q.size()) begin
        check("tbl_addr", 32'(wr_addr_q[i]), 32'(i));
        check("tbl_data", 32'(wr_data_q[i]), 32'(vecs[i].exp));
      end
    end
    check("f2_fcount", 32'(frame_count), 32'd2);

    // Odd byte count line
    clear_log();
    frame_start();
    send_line(H, 8'hF8, 8'h1F, 1'b1);
    check("odd_line_lerr", 32'(line_err), 32'd1);
    for (int l = 1; l < V; l++) send_line(H, 8'hF8, 8'h1F, 1'b0);
    frame_end();
    check("odd_lerr_sticky", 32'(line_err), 32'd1);

    // Flag clears at frame start; short line sets it; address is not realigned
    clear_log();
    frame_start();
    check("lerr_clear", 32'(line_err), 32'd0);
    send_line(H, 8'h07, 8'hE0, 1'b0);
    check("good_line_lerr", 32'(line_err), 32'd0);
    send_line(H - 1, 8'h07, 8'hE0, 1'b0);
    check("short_line_lerr", 32'(line_err), 32'd1);
    send_line(H, 8'h07, 8'hE0, 1'b0);
    frame_end();
    check("f4_writes", 32'(wr_addr_q.size()), 32'(TOTAL - 1));
    check("f4_last_addr",
          (wr_addr_q.size() > 0) ? 32'(wr_addr_q[wr_addr_q.size()-1]) : 32'hFFFF_FFFF,
          32'(TOTAL - 2));

    // One extra line: its pixels are suppressed
    clear_log();
    frame_start();
    for (int l = 0; l < V + 1; l++) send_line(H, 8'hF8, 8'h1F, 1'b0);
    frame_end();
    check("ovf_writes", 32'(wr_addr_q.size()), 32'(TOTAL));
    check("ovf_flag",   32'(overflow),         32'd1);
    check("ovf_addr",   32'(pix_addr),         32'(TOTAL));
    check("ovf_lerr",   32'(line_err),         32'd0);

    // Drop enable mid-frame: frame completes, then capture stops
    clear_log();
    frame_start();
    check("ovf_clear", 32'(overflow), 32'd0);
    send_line(H, 8'hF8, 8'h1F, 1'b0);
    enable = 1'b0;
    for (int l = 1; l < V; l++) send_line(H, 8'hF8, 8'h1F, 1'b0);
    frame_end();
    check("dis_writes", 32'(wr_addr_q.size()), 32'(TOTAL));
    check("dis_fd",     32'(fd_cnt - fd0),     32'd1);
    check("dis_fcount", 32'(frame_count),      32'd6);
    clear_log();
    frame_start();
    for (int l = 0; l < V; l++) send_line(H, 8'hF8, 8'h1F, 1'b0);
    frame_end();
    check("idle_writes", 32'(wr_addr_q.size()), 32'd0);
    check("idle_fd",     32'(fd_cnt - fd0),     32'd0);
    check("idle_fcount", 32'(frame_count),      32'd6);

    // Reset in the middle of a line
    enable = 1'b1;
    tick(2);
    frame_start();
    @(negedge clk); cam_href = 1'b1;
    for (int i = 0; i < 3; i++) send_pixel(8'hFF, 8'hFF);
    send_byte(8'hFF);
    check("pre_rst_addr", 32'(pix_addr), 32'd3);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("mid_rst_addr",   32'(pix_addr),    32'd0);
    check("mid_rst_data",   32'(pix_data),    32'd0);
    check("mid_rst_we",     32'(pix_we),      32'd0);
    check("mid_rst_fd",     32'(frame_done),  32'd0);
    check("mid_rst_fcount", 32'(frame_count), 32'd0);
    check("mid_rst_lerr",   32'(line_err),    32'd0);
    check("mid_rst_ovf",    32'(overflow),    32'd0);
    cam_href = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    clear_log();
    send_line(H, 8'hF8, 8'h1F, 1'b0);
    check("no_vsync_writes", 32'(wr_addr_q.size()), 32'd0);

    // Write and frame_done latency
    clear_log();
    frame_start();
    @(negedge clk); cam_href = 1'b1;
    send_byte(8'h07);
    @(negedge clk); cam_data = 8'hE0;
    @(negedge clk); cam_pclk = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("lat_we", 32'(pix_we), 32'(k == 4));
      if (k == 4) begin
        check("lat_data", 32'(pix_data), 32'h00F0);
        check("lat_addr", 32'(pix_addr), 32'd0);
      end
      if (k == 2) cam_pclk = 1'b0;
    end
    for (int i = 1; i < H; i++) send_pixel(8'h00, 8'h1F);
    @(negedge clk); cam_href = 1'b0;
    tick(5);
    for (int l = 1; l < V; l++) send_line(H, 8'h00, 8'h1F, 1'b0);
    @(negedge clk); cam_vsync = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("lat_fd", 32'(frame_done), 32'(k == 4));
    end
    tick(3);
    check("lat_fcount", 32'(frame_count), 32'd1);
    check("lat_writes", 32'(wr_addr_q.size()), 32'(TOTAL));

    // frame_count wrap over 256 frames
    @(negedge clk); rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    clear_log();
    for (int f = 0; f < 255; f++) begin
      frame_start();
      frame_end();
    end
    check("wrap_255", 32'(frame_count), 32'd255);
    frame_start();
    frame_end();
    check("wrap_0",  32'(frame_count),   32'd0);
    check("wrap_fd", 32'(fd_cnt - fd0),  32'd256);

    check("fd_we_clash", 32'(clash_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cam_capture.md
# cam_capture

Receive side of the camera path: accepts the OV7670-style parallel byte stream arriving on the JA/JB PMOD headers (pixel clock, VSYNC, HREF, 8-bit data) and converts it into frame-buffer writes. Pixels arrive as two-byte RGB565 words. Each is converted to the 12-bit 4:4:4 format used by the VGA output and written at a linear frame-buffer address. The block runs entirely in the system clock domain, oversampling the camera pixel clock; it sits between the PMOD pins and the frame-buffer BRAM write port that xvga-timed display logic reads.

## Interface
- H_ACTIVE, 320, pixels per line
- V_ACTIVE, 240, lines per frame
- ADDR_W, 17, frame-buffer address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE

- clk  in  1  system clock (65 MHz in the top level); all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cam_pclk  in  1  camera pixel clock, asynchronous; treated as data
- cam_vsync  in  1  camera VSYNC, high between frames
- cam_href  in  1  camera HREF, high while line bytes are valid
- cam_data  in  8  camera data byte
- enable  in  1  arm capture
- pix_addr  out  ADDR_W  frame-buffer write address
- pix_data  out  12  {R[3:0],G[3:0],B[3:0]}
- pix_we  out  1  one-cycle write strobe
- frame_done  out  1  one-cycle pulse at end of a captured frame
- frame_count  out  8  completed frames, wraps 255->0
- line_err  out  1  sticky: a line had an odd byte count or a pixel count other than H_ACTIVE
- overflow  out  1  sticky: a pixel arrived with the address at or beyond H_ACTIVE*V_ACTIVE

## Operation
- cam_pclk, cam_vsync, cam_href and cam_data pass through two-flop synchronizers. A third register on pclk detects its rising edge (pclk_rise).
- FSM states:
  - IDLE: -> WAIT_FRAME when enable=1.
  - WAIT_FRAME: -> CAPTURE on a synced vsync falling edge; clears the address, byte phase and column counters.
  - CAPTURE: processes bytes. On a vsync rising edge it pulses frame_done, increments frame_count, then -> WAIT_FRAME if enable=1, else -> IDLE.
- enable is sampled only in IDLE and at frame end. Deasserting enable mid-frame completes the current frame.
- Byte handling in CAPTURE, on pclk_rise with href=1:
  - phase 0: latch the byte as hi (R[4:0],G[5:3]).
  - phase 1: form the pixel and issue a write.
  - The phase toggles on each byte.
- Pixel conversion: R = hi[7:4], G = {hi[2:0],lo[7]}, B = lo[4:1] (truncation of 5/6/5 to 4/4/4).
- Write: pix_we=1 for one cycle with the current pix_addr. pix_addr then increments by 1 and the column counter increments.
- Href falling edge:
  - If phase==1 (odd byte count) or column != H_ACTIVE, set line_err.
  - Reset the phase and column counters. pix_addr is not realigned.
- Address guard: if pix_addr >= H_ACTIVE*V_ACTIVE when a pixel completes, suppress pix_we, set overflow, and hold pix_addr.
- line_err and overflow clear only on reset or on the WAIT_FRAME->CAPTURE transition.
- Bytes arriving in IDLE or WAIT_FRAME are ignored.

## Timing
- Reset values: pix_addr=0, pix_data=0, pix_we=0, frame_done=0, frame_count=0, line_err=0, overflow=0, FSM=IDLE, phase=0.
- Reset mid-frame returns the FSM to IDLE immediately. Capture resumes only after a fresh vsync falling edge.
- Requirement: f_clk >= 4*f_cam_pclk, and cam_pclk high/low each >= 2 clk periods.
- Latency: pix_we, pix_data and pix_addr are valid together exactly 3 clk cycles after the first clk edge that samples cam_pclk high for the second byte of a pixel.
- pix_data and pix_addr are registered and change only with pix_we.
- frame_done is asserted 3 cycles after the first clk edge sampling cam_vsync high; it is never coincident with pix_we.
- If href falls and vsync rises in the same synced cycle, evaluate the line check first, then frame_done.

## Configuration
- CAM_CAPTURE_TESTPAT_EN defined: pix_data is replaced by 8 vertical colour bars. Bar index = column*8/H_ACTIVE, colour = {bar[2]?4'hF:0, bar[1]?4'hF:0, bar[0]?4'hF:0}. Write timing, addressing and error flags still follow the camera stream.
- Not defined: pix_data is taken from the camera as above and no bar logic is synthesized.

## Test plan
- Reset then enable; full 320x240 frame with every byte pair 0xF8,0x1F -> 76800 writes, pix_data=0xF0F, last pix_addr=76799, one frame_done, frame_count=1, flags 0.
- Byte pair 0x07,0xE0 -> pix_data=0x0F0; pair 0x00,0x1F -> 0x00F.
- One line with 641 bytes -> line_err=1 after href falls; flag cleared at next frame start.
- Frame with 241 lines -> the last 320 pixels produce no pix_we, overflow=1, and pix_addr holds at 76800.
- Deassert enable mid-frame -> frame completes, FSM goes to IDLE, next frame produces no writes. Assert rst_n=0 mid-line -> all outputs 0 immediately.
- 256 back-to-back frames -> frame_count wraps to 0 with exactly 256 frame_done pulses.
